rggen_bit_field_rws_mc: RTL and testbench
=========================================

# rggen_bit_field_rws_mc

Multi-channel read-write bit field with hardware set, for rggen register blocks where several hardware agents update one software-visible field. Up to SET_CHANNELS requesters load or OR-merge a value under fixed priority, arbitrated against bus writes by WRITE_FIRST. A per-channel acknowledge gives requesters a hold-until-accepted handshake. A sticky update flag tells software that hardware changed the field since its last read.

## Interface
- WIDTH, 8: field width in bits (1 or more).
- INITIAL_VALUE, {WIDTH{1'b0}}: reset value of the field.
- SET_CHANNELS, 2: number of hardware set channels (1–16).
- WRITE_FIRST, 1: nonzero means a bus write beats any set in the same cycle; 0 means a set beats the write.
- SET_MODE, 0: 0 means the winning channel's value replaces the field; 1 means it is ORed into the field.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, **synchronous, active-high**.
- i_bit_field_valid  in  1  bus access strobe.
- i_bit_field_read_mask  in  WIDTH  bus read byte/bit mask.
- i_bit_field_write_mask  in  WIDTH  bus write bit mask.
- i_bit_field_write_data  in  WIDTH  bus write data.
- o_bit_field_read_data  out  WIDTH  field value (r_value).
- o_bit_field_value  out  WIDTH  field value (r_value).
- i_set  in  SET_CHANNELS  per-channel set request.
- i_value  in  SET_CHANNELS*WIDTH  set data; channel k uses bits [k*WIDTH +: WIDTH].
- o_set_ack  out  SET_CHANNELS  one-hot acceptance, combinational.
- o_value  out  WIDTH  field value to hardware (r_value).
- o_updated  out  1  sticky "hardware changed field" flag.

## Operation
- Write access: i_bit_field_valid && |i_bit_field_write_mask. Write result = (r_value & ~mask) | (data & mask).
- Read access: i_bit_field_valid && |i_bit_field_read_mask && no write access.
- Channel arbitration: lowest-index asserted i_set wins (g = winner). Losing channels get no ack and hold their request.
- Set result by mode:
  - SET_MODE=0: i_value[g].
  - SET_MODE=1: r_value | i_value[g].
- Conflict when both a write access and any set are present:
  - WRITE_FIRST!=0: the write is applied; o_set_ack is all zero; requesters retry.
  - WRITE_FIRST==0: the set is applied and acked; the write is discarded.
- o_set_ack[g]=1 exactly in the cycle the set is applied. A requester that sees ack must drop or replace its request by the next cycle, or it is applied again.
- o_updated:
  - Set at the edge where an applied set produces a next value different from r_value.
  - Cleared at the edge ending a read access.
  - Simultaneous value-changing set and read: the set wins, so the flag stays or becomes 1.
  - A bus write never sets the flag.
- No access and no set: r_value holds.
- Reset:
  - r_value=INITIAL_VALUE, o_updated=0.
  - o_set_ack forced to 0 while i_rst=1; sets and writes in that cycle are ignored.

## Timing
- Field update latency: one cycle. New value is visible on all three value outputs in the cycle after the access or ack cycle.
- Read data is r_value with no extra pipeline. A read and a set in the same cycle return the pre-set value.
- o_set_ack is combinational from i_set, i_bit_field_valid, i_bit_field_write_mask and i_rst. It has no dependence on r_value.
- Back-to-back sets from different channels in consecutive cycles are each accepted. Throughput is one set per cycle.
- Reset asserted mid-handshake: the pending request is not acked; after release the request is arbitrated normally.

## Test plan
- Reset with INITIAL_VALUE=8'hA5 -> outputs 8'hA5, o_updated=0, o_set_ack=0 even with i_set=2'b11 held during reset.
- i_set=2'b11, i_value={8'h22,8'h11}, SET_MODE=0 -> o_set_ack=2'b01, value 8'h11 next cycle, o_updated=1. Channel 1 is acked the following cycle, value becomes 8'h22.
- WRITE_FIRST=1: write mask 8'h0F, data 8'h3C together with i_set[0] carrying 8'hFF, from 8'h00 -> value 8'h0C, ack 0. Next cycle (no write) ack=1, value 8'hFF.
- WRITE_FIRST=0, same stimulus -> ack[0]=1, value 8'hFF, write discarded.
- SET_MODE=1: value 8'h81, set 8'h06 -> 8'h87, o_updated=1. Read access -> o_updated=0. Set 8'h01 (no change) -> o_updated stays 0.
- Read access in the same cycle as a value-changing set -> read data returns the old value, o_updated=1 afterward.

Source files
------------

// File: rtl/rggen_bit_field_rws_mc.sv
// Multi-channel read-write bit field with hardware set.
// Several hardware agents can load or OR-merge a value into one
// software-visible field. The lowest-index requester wins, and a one-hot
// acknowledge tells it that its value was taken. A sticky flag records
// that hardware changed the field since software last read it.
module rggen_bit_field_rws_mc #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}},
  parameter int               SET_CHANNELS  = 2,
  parameter int               WRITE_FIRST   = 1,
  parameter int               SET_MODE      = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_bit_field_valid,
  input  logic [WIDTH-1:0]              i_bit_field_read_mask,
  input  logic [WIDTH-1:0]              i_bit_field_write_mask,
  input  logic [WIDTH-1:0]              i_bit_field_write_data,
  output logic [WIDTH-1:0]              o_bit_field_read_data,
  output logic [WIDTH-1:0]              o_bit_field_value,
  input  logic [SET_CHANNELS-1:0]       i_set,
  input  logic [SET_CHANNELS*WIDTH-1:0] i_value,
  output logic [SET_CHANNELS-1:0]       o_set_ack,
  output logic [WIDTH-1:0]              o_value,
  output logic                          o_updated
);

  logic [WIDTH-1:0]        value_reg;
  logic [WIDTH-1:0]        value_next;
  logic                    updated_reg;
  logic                    updated_next;

  logic                    write_access;
  logic                    read_access;
  logic [SET_CHANNELS-1:0] grant;
  logic                    any_set;
  logic                    set_apply;
  logic [WIDTH-1:0]        masked_value [SET_CHANNELS];
  logic [WIDTH-1:0]        set_data;
  logic [WIDTH-1:0]        set_result;
  logic [WIDTH-1:0]        write_result;

  assign write_access = i_bit_field_valid && (|i_bit_field_write_mask);
  assign read_access  = i_bit_field_valid && (|i_bit_field_read_mask) && !write_access;
  assign any_set      = |i_set;

  // Fixed priority: a channel wins only if no lower-index channel requests.
  // Each channel's data is gated by its grant so the winner can be OR-selected.
  for (genvar gi = 0; gi < SET_CHANNELS; gi++) begin : g_channel
    if (gi == 0) begin : g_first
      assign grant[gi] = i_set[gi];
    end else begin : g_rest
      assign grant[gi] = i_set[gi] && !(|i_set[gi-1:0]);
    end
    assign masked_value[gi] = i_value[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
  end

  // Winner's data: the grant is one-hot, so ORing the gated values selects it.
  always_comb begin
    set_data = '0;
    for (int i = 0; i < SET_CHANNELS; i++) begin
      set_data = set_data | masked_value[i];
    end
  end

  // A set is taken unless reset is active or a concurrent write has priority.
  // Depends only on request/bus/reset inputs, never on the stored value.
  assign set_apply = any_set && !i_rst && (!write_access || (WRITE_FIRST == 0));
  assign o_set_ack = set_apply ? grant : '0;

  assign set_result   = (SET_MODE != 0) ? (value_reg | set_data) : set_data;
  assign write_result = (value_reg & ~i_bit_field_write_mask) |
                        (i_bit_field_write_data & i_bit_field_write_mask);

  // Next field value and sticky flag; a value-changing set beats a read clear.
  always_comb begin
    value_next   = value_reg;
    updated_next = updated_reg;
    if (set_apply) begin
      value_next = set_result;
    end else if (write_access) begin
      value_next = write_result;
    end
    if (set_apply && (set_result != value_reg)) begin
      updated_next = 1'b1;
    end else if (read_access) begin
      updated_next = 1'b0;
    end
  end

  // Field and flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_reg   <= INITIAL_VALUE;
      updated_reg <= 1'b0;
    end else begin
      value_reg   <= value_next;
      updated_reg <= updated_next;
    end
  end

  assign o_bit_field_read_data = value_reg;
  assign o_bit_field_value     = value_reg;
  assign o_value               = value_reg;
  assign o_updated             = updated_reg;

endmodule

// File: tb/tb_rggen_bit_field_rws_mc.sv
// Bench for rggen_bit_field_rws_mc: three instances with different
// priority/mode settings, directed per-cycle stimulus, and a queue of
// expected per-cycle outputs consumed by an independent monitor.
module tb_rggen_bit_field_rws_mc;

  logic        clk;
  logic        rst;
  logic        valid [3];
  logic [7:0]  rmask [3];
  logic [7:0]  wmask [3];
  logic [7:0]  wdata [3];
  logic [1:0]  set   [3];
  logic [15:0] val   [3];
  logic [7:0]  rdata [3];
  logic [7:0]  fval  [3];
  logic [7:0]  hval  [3];
  logic [1:0]  ack   [3];
  logic        upd   [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    string      name;
    logic [7:0] value;
    logic       upd;
    logic [1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: write wins, replace mode, nonzero reset value.
  rggen_bit_field_rws_mc #(
    .WIDTH(8), .INITIAL_VALUE(8'hA5), .SET_CHANNELS(2), .WRITE_FIRST(1), .SET_MODE(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid[0]),
    .i_bit_field_read_mask(rmask[0]), .i_bit_field_write_mask(wmask[0]),
    .i_bit_field_write_data(wdata[0]), .o_bit_field_read_data(rdata[0]),
    .o_bit_field_value(fval[0]), .i_set(set[0]), .i_value(val[0]),
    .o_set_ack(ack[0]), .o_value(hval[0]), .o_updated(upd[0])
  );

  // Instance 1: set wins, replace mode.
  rggen_bit_field_rws_mc #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .SET_CHANNELS(2), .WRITE_FIRST(0), .SET_MODE(0)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid[1]),
    .i_bit_field_read_mask(rmask[1]), .i_bit_field_write_mask(wmask[1]),
    .i_bit_field_write_data(wdata[1]), .o_bit_field_read_data(rdata[1]),
    .o_bit_field_value(fval[1]), .i_set(set[1]), .i_value(val[1]),
    .o_set_ack(ack[1]), .o_value(hval[1]), .o_updated(upd[1])
  );

  // Instance 2: write wins, OR-merge mode.
  rggen_bit_field_rws_mc #(
    .WIDTH(8), .INITIAL_VALUE(8'h81), .SET_CHANNELS(2), .WRITE_FIRST(1), .SET_MODE(1)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid[2]),
    .i_bit_field_read_mask(rmask[2]), .i_bit_field_write_mask(wmask[2]),
    .i_bit_field_write_data(wdata[2]), .o_bit_field_read_data(rdata[2]),
    .o_bit_field_value(fval[2]), .i_set(set[2]), .i_value(val[2]),
    .o_set_ack(ack[2]), .o_value(hval[2]), .o_updated(upd[2])
  );

  task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %02h expected %02h", name, d, act, req);
    end
  endtask

  // Monitor: every falling edge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".read_data"}, e.dut, rdata[e.dut], e.value);
      chk({e.name, ".field_value"}, e.dut, fval[e.dut], e.value);
      chk({e.name, ".value"}, e.dut, hval[e.dut], e.value);
      chk({e.name, ".updated"}, e.dut, {7'd0, upd[e.dut]}, {7'd0, e.upd});
      chk({e.name, ".set_ack"}, e.dut, {6'd0, ack[e.dut]}, {6'd0, e.ack});
      $display("cycle %s dut%0d value=%02h updated=%0b ack=%02b", e.name, e.dut,
               hval[e.dut], upd[e.dut], ack[e.dut]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic v, input logic [7:0] rm, input logic [7:0] wm,
                     input logic [7:0] wd, input logic [1:0] s, input logic [15:0] vl);
    valid[d] = v;
    rmask[d] = rm;
    wmask[d] = wm;
    wdata[d] = wd;
    set[d]   = s;
    val[d]   = vl;
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000);
  endtask

  task automatic expect_out(input int d, input string n, input logic [7:0] v,
                            input logic u, input logic [1:0] a);
    exp_t e;
    e.dut = d; e.name = n; e.value = v; e.upd = u; e.ack = a;
    exp_q.push_back(e);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(i);
    drv(0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b11, 16'h2211);

    // Reset: initial values, no ack even with both requests held.
    tick();
    expect_out(0, "reset", 8'hA5, 1'b0, 2'b00);
    expect_out(1, "reset", 8'h00, 1'b0, 2'b00);
    expect_out(2, "reset", 8'h81, 1'b0, 2'b00);

    // Priority: channel 0 first, then channel 1.
    tick(); rst = 1'b0;
    expect_out(0, "prio_ch0", 8'hA5, 1'b0, 2'b01);
    tick(); drv(0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 16'h2211);
    expect_out(0, "prio_ch1", 8'h11, 1'b1, 2'b10);
    tick(); drv(0, 1'b1, 8'hFF, 8'h00, 8'h00, 2'b00, 16'h0000);
    expect_out(0, "read_clear", 8'h22, 1'b1, 2'b00);
    tick(); idle(0);
    expect_out(0, "after_read", 8'h22, 1'b0, 2'b00);

    // Read concurrent with a changing set returns the old value.
    tick(); drv(0, 1'b1, 8'hFF, 8'h00, 8'h00, 2'b01, 16'h0033);
    expect_out(0, "read_set", 8'h22, 1'b0, 2'b01);
    tick(); drv(0, 1'b1, 8'hFF, 8'h00, 8'h00, 2'b00, 16'h0000);
    expect_out(0, "set_wins_flag", 8'h33, 1'b1, 2'b00);

    // Bus write does not raise the flag.
    tick(); drv(0, 1'b1, 8'h00, 8'hFF, 8'h00, 2'b00, 16'h0000);
    expect_out(0, "write_clr", 8'h33, 1'b0, 2'b00);

    // Write beats set: write applied, no ack, request retried next cycle.
    tick(); drv(0, 1'b1, 8'h00, 8'h0F, 8'h3C, 2'b01, 16'h00FF);
    expect_out(0, "wf_conflict", 8'h00, 1'b0, 2'b00);
    tick(); drv(0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 16'h00FF);
    expect_out(0, "wf_retry", 8'h0C, 1'b0, 2'b01);
    tick(); idle(0);
    expect_out(0, "wf_result", 8'hFF, 1'b1, 2'b00);

    // Set beats write: set applied and acked, write discarded.
    tick(); drv(1, 1'b1, 8'h00, 8'h0F, 8'h3C, 2'b01, 16'h00FF);
    expect_out(1, "sf_conflict", 8'h00, 1'b0, 2'b01);
    tick(); idle(1);
    expect_out(1, "sf_result", 8'hFF, 1'b1, 2'b00);

    // OR-merge mode.
    tick(); drv(2, 1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 16'h0006);
    expect_out(2, "or_set", 8'h81, 1'b0, 2'b01);
    tick(); drv(2, 1'b1, 8'hFF, 8'h00, 8'h00, 2'b00, 16'h0000);
    expect_out(2, "or_read", 8'h87, 1'b1, 2'b00);
    tick(); drv(2, 1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 16'h0001);
    expect_out(2, "or_nochange", 8'h87, 1'b0, 2'b01);
    tick(); drv(2, 1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 16'h1000);
    expect_out(2, "or_ch1", 8'h87, 1'b0, 2'b10);
    tick(); idle(2);
    expect_out(2, "or_result", 8'h97, 1'b1, 2'b00);

    // Reset in the middle of a handshake: no ack, then normal arbitration.
    tick(); rst = 1'b1; drv(0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 16'h0044);
    expect_out(0, "rst_pending", 8'hFF, 1'b1, 2'b00);
    tick(); rst = 1'b0;
    expect_out(0, "rst_release", 8'hA5, 1'b0, 2'b01);
    tick(); idle(0);
    expect_out(0, "rst_result", 8'h44, 1'b1, 2'b00);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
